// File: rtl/multiport_regfile_sb.sv
// Decode-stage integer register file with NRP read ports, NWP writeback lanes,
// optional same-cycle write-to-read forwarding and a per-register busy scoreboard.
// Register 0 reads as zero and is never marked busy.
module multiport_regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned NRP    = 2,
  parameter int unsigned NWP    = 2,
  parameter bit          BYPASS = 1'b1,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NRP*AW-1:0]    i_rs_addr,
  output logic [NRP*XLEN-1:0]  o_rs_data,
  output logic [NRP-1:0]       o_rs_busy,
  input  logic [NWP-1:0]       i_wr_en,
  input  logic [NWP*AW-1:0]    i_wr_addr,
  input  logic [NWP*XLEN-1:0]  i_wr_data,
  input  logic                 i_issue_valid,
  input  logic [AW-1:0]        i_issue_rd,
  output logic [AW:0]          o_busy_count
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic [AW:0]     r_busy_count;

  logic [NREG-1:0] w_busy_d;
  logic [AW:0]     w_count_d;

  // Scoreboard next state: retire writebacks first, then a new issue overrides the clear.
  always_comb begin
    w_busy_d = r_busy;
    for (int l = 0; l < int'(NWP); l++) begin
      if (i_wr_en[l]) begin
        w_busy_d[i_wr_addr[l*AW +: AW]] = 1'b0;
      end
    end
    if (i_issue_valid) begin
      w_busy_d[i_issue_rd] = 1'b1;
    end
    w_busy_d[0] = 1'b0;
  end

  // Population count of the next busy vector so the count tracks busy[] on the same edge.
  always_comb begin
    w_count_d = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      w_count_d = w_count_d + {{AW{1'b0}}, w_busy_d[i]};
    end
  end

  // Register storage; later lanes are written last so the highest lane wins on a collision.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int l = 0; l < int'(NWP); l++) begin
        if (i_wr_en[l] && (i_wr_addr[l*AW +: AW] != '0)) begin
          r_regs[i_wr_addr[l*AW +: AW]] <= i_wr_data[l*XLEN +: XLEN];
        end
      end
    end
  end

  // Scoreboard and busy count registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      r_busy       <= w_busy_d;
      r_busy_count <= w_count_d;
    end
  end

  // Combinational read ports with optional forwarding from the writeback lanes.
  always_comb begin
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_hit;
    o_rs_data = '0;
    o_rs_busy = '0;
    w_addr    = '0;
    w_data    = '0;
    w_hit     = 1'b0;
    for (int p = 0; p < int'(NRP); p++) begin
      w_addr = i_rs_addr[p*AW +: AW];
      w_data = r_regs[w_addr];
      w_hit  = 1'b0;
      if (BYPASS) begin
        for (int l = 0; l < int'(NWP); l++) begin
          if (i_wr_en[l] && (i_wr_addr[l*AW +: AW] == w_addr)) begin
            w_data = i_wr_data[l*XLEN +: XLEN];
            w_hit  = 1'b1;
          end
        end
      end
      if (w_addr == '0) begin
        o_rs_data[p*XLEN +: XLEN] = '0;
        o_rs_busy[p]              = 1'b0;
      end else begin
        o_rs_data[p*XLEN +: XLEN] = w_data;
        // A producer writing back this cycle already supplies the value via the bypass.
        o_rs_busy[p]              = r_busy[w_addr] && !w_hit;
      end
    end
  end

  assign o_busy_count = r_busy_count;

endmodule

// File: tb/tb_multiport_regfile_sb.sv
// Bench for multiport_regfile_sb: one bypassing and one non-bypassing instance share
// the same stimulus and are compared against an array-based reference model.
module tb_multiport_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int NWP  = 2;
  localparam int AW   = 5;

  logic                clock = 1'b0;
  logic                reset;
  logic [NRP*AW-1:0]   rs_addr;
  logic [NRP*XLEN-1:0] rs_data_b1, rs_data_b0;
  logic [NRP-1:0]      rs_busy_b1, rs_busy_b0;
  logic [NWP-1:0]      wr_en;
  logic [NWP*AW-1:0]   wr_addr;
  logic [NWP*XLEN-1:0] wr_data;
  logic                issue_valid;
  logic [AW-1:0]       issue_rd;
  logic [AW:0]         busy_count_b1, busy_count_b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [XLEN-1:0] m_regs [NREG];
  bit              m_busy [NREG];

  always #5 clock = ~clock;

  multiport_regfile_sb #(
    .XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP), .BYPASS(1'b1)
  ) u_dut_b1 (
    .clock        (clock),
    .reset        (reset),
    .i_rs_addr    (rs_addr),
    .o_rs_data    (rs_data_b1),
    .o_rs_busy    (rs_busy_b1),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_issue_valid(issue_valid),
    .i_issue_rd   (issue_rd),
    .o_busy_count (busy_count_b1)
  );

  multiport_regfile_sb #(
    .XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP), .BYPASS(1'b0)
  ) u_dut_b0 (
    .clock        (clock),
    .reset        (reset),
    .i_rs_addr    (rs_addr),
    .o_rs_data    (rs_data_b0),
    .o_rs_busy    (rs_busy_b0),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_issue_valid(issue_valid),
    .i_issue_rd   (issue_rd),
    .o_busy_count (busy_count_b0)
  );

  task automatic check_val(input string tag, input logic [XLEN-1:0] got,
                           input logic [XLEN-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_rs(input int p, input int a);
    rs_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int l, input bit en, input int a, input logic [XLEN-1:0] d);
    wr_en[l]                = en;
    wr_addr[l*AW +: AW]     = AW'(a);
    wr_data[l*XLEN +: XLEN] = d;
  endtask

  task automatic idle();
    wr_en       = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
  endtask

  // Expected outputs for the inputs currently applied, from the model state.
  task automatic check_outputs();
    int              a;
    bit              hit;
    logic [XLEN-1:0] fwd;
    logic [XLEN-1:0] e1, e0;
    int              cnt;
    for (int p = 0; p < NRP; p++) begin
      a   = int'(rs_addr[p*AW +: AW]);
      hit = 0;
      fwd = '0;
      for (int l = 0; l < NWP; l++) begin
        if (wr_en[l] && int'(wr_addr[l*AW +: AW]) == a) begin
          hit = 1;
          fwd = wr_data[l*XLEN +: XLEN];
        end
      end
      e0 = (a == 0) ? '0 : m_regs[a];
      e1 = (a == 0) ? '0 : (hit ? fwd : m_regs[a]);
      check_val($sformatf("rdata_byp1_p%0d_x%0d", p, a), rs_data_b1[p*XLEN +: XLEN], e1);
      check_val($sformatf("rdata_byp0_p%0d_x%0d", p, a), rs_data_b0[p*XLEN +: XLEN], e0);
      check_val($sformatf("rbusy_byp1_p%0d_x%0d", p, a), XLEN'(rs_busy_b1[p]),
                XLEN'((a != 0) && m_busy[a] && !hit));
      check_val($sformatf("rbusy_byp0_p%0d_x%0d", p, a), XLEN'(rs_busy_b0[p]),
                XLEN'((a != 0) && m_busy[a]));
    end
    cnt = 0;
    for (int i = 0; i < NREG; i++) cnt += int'(m_busy[i]);
    check_val("busy_count_byp1", XLEN'(busy_count_b1), XLEN'(cnt));
    check_val("busy_count_byp0", XLEN'(busy_count_b0), XLEN'(cnt));
  endtask

  // Apply the architectural effect of one clock edge to the model.
  task automatic model_update();
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 0;
      end
    end else begin
      for (int l = 0; l < NWP; l++) begin
        if (wr_en[l]) begin
          if (wr_addr[l*AW +: AW] != 0) m_regs[wr_addr[l*AW +: AW]] = wr_data[l*XLEN +: XLEN];
          m_busy[wr_addr[l*AW +: AW]] = 0;
        end
      end
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1;
    end
  endtask

  task automatic cycle();
    #1 check_outputs();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  initial begin
    reset       = 1'b1;
    rs_addr     = '0;
    wr_en       = '0;
    wr_addr     = '0;
    wr_data     = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;

    // Two reset cycles, then read every register.
    repeat (2) begin
      @(posedge clock);
      model_update();
    end
    @(negedge clock);
    reset = 1'b0;
    for (int a = 0; a < NREG; a += 2) begin
      set_rs(0, a);
      set_rs(1, a + 1);
      cycle();
    end

    // Same-cycle read of a write: forwarded vs. stored.
    set_wr(0, 1, 5, 32'hDEADBEEF);
    set_rs(0, 5);
    set_rs(1, 5);
    #1 check_val("x5_fwd_same_cycle", rs_data_b1[0 +: XLEN], 32'hDEADBEEF);
    check_val("x5_nofwd_same_cycle", rs_data_b0[0 +: XLEN], 32'h0);
    cycle();
    idle();
    #1 check_val("x5_nofwd_next_cycle", rs_data_b0[0 +: XLEN], 32'hDEADBEEF);
    cycle();

    // Two lanes hit the same register: lane 1 wins.
    set_wr(0, 1, 3, 32'h11);
    set_wr(1, 1, 3, 32'h22);
    set_rs(0, 3);
    cycle();
    idle();
    #1 check_val("x3_highest_lane", rs_data_b0[0 +: XLEN], 32'h22);
    cycle();

    // Writes and issues to x0 have no effect.
    set_wr(0, 1, 0, 32'hFFFF_FFFF);
    issue_valid = 1'b1;
    issue_rd    = '0;
    set_rs(0, 0);
    cycle();
    idle();
    #1 check_val("x0_reads_zero", rs_data_b1[0 +: XLEN], 32'h0);
    check_val("x0_no_busy_count", XLEN'(busy_count_b1), 32'd0);
    cycle();

    // Issue x7, then write it back.
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    set_rs(0, 7);
    cycle();
    idle();
    #1 check_val("x7_busy", XLEN'(rs_busy_b1[0]), 32'd1);
    check_val("x7_busy_count", XLEN'(busy_count_b1), 32'd1);
    set_wr(0, 1, 7, 32'h42);
    #1 check_val("x7_busy_masked_by_wb", XLEN'(rs_busy_b1[0]), 32'd0);
    cycle();
    idle();
    #1 check_val("x7_retired_count", XLEN'(busy_count_b1), 32'd0);
    cycle();

    // Issue and writeback of the same register: set wins; then reset clears it.
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    set_rs(0, 9);
    cycle();
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    set_wr(1, 1, 9, 32'h99);
    cycle();
    idle();
    #1 check_val("x9_still_busy", XLEN'(rs_busy_b0[0]), 32'd1);
    check_val("x9_busy_count", XLEN'(busy_count_b0), 32'd1);
    reset = 1'b1;
    set_wr(0, 1, 4, 32'h1234);
    issue_valid = 1'b1;
    issue_rd    = 5'd4;
    cycle();
    reset = 1'b0;
    idle();
    set_rs(1, 4);
    #1 check_val("reset_count_zero", XLEN'(busy_count_b1), 32'd0);
    check_val("reset_drops_write", rs_data_b0[XLEN +: XLEN], 32'h0);
    cycle();

    // Randomised traffic, biased toward a few registers to provoke collisions.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < NRP; p++) begin
        set_rs(p, ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, NREG - 1));
      end
      for (int l = 0; l < NWP; l++) begin
        set_wr(l, ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, NREG - 1),
               $urandom());
      end
      issue_valid = ($urandom_range(0, 1) != 0);
      issue_rd    = AW'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7)
                                                    : $urandom_range(0, NREG - 1));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
